// File: rtl/iob_cache_port_arbiter.sv
// Merges N_PORTS IOb-native master ports onto the single cache frontend port.
// The granted request is held in registers until the cache completes it.
module iob_cache_port_arbiter #(
  parameter int N_PORTS  = 4,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int NBYTES   = DATA_W / 8,
  parameter int ARB_MODE = 0,
  parameter int PORT_W   = $clog2(N_PORTS)
) (
  input  logic                       ap_clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         s_valid,
  input  logic [N_PORTS*ADDR_W-1:0]  s_addr,
  input  logic [N_PORTS*DATA_W-1:0]  s_wdata,
  input  logic [N_PORTS*NBYTES-1:0]  s_wstrb,
  output logic [N_PORTS*DATA_W-1:0]  s_rdata,
  output logic [N_PORTS-1:0]         s_ready,
  output logic                       m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [NBYTES-1:0]          m_wstrb,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_ready,
  output logic [PORT_W-1:0]          grant_id,
  output logic                       busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [PORT_W:0] NP = (PORT_W+1)'(N_PORTS);

  state_t              state;
  logic [PORT_W-1:0]   last_grant;
  logic [N_PORTS-1:0]  grant_oh;
  logic [N_PORTS-1:0]  req;
  logic [PORT_W:0]     start;
  logic [PORT_W:0]     idx_ext;
  logic [PORT_W-1:0]   win_idx;
  logic                win_found;
  logic                capture;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NBYTES-1:0]   sel_wstrb;

  assign grant_oh = N_PORTS'(1) << grant_id;

  // The master being completed still shows valid in its m_ready cycle.
  assign req = (state == BUSY) ? (s_valid & ~grant_oh) : s_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    start     = '0;
    idx_ext   = '0;
    win_found = 1'b0;
    win_idx   = '0;
    if (ARB_MODE == 0) begin
      start = {1'b0, last_grant} + (PORT_W+1)'(1);
      if (start >= NP) start = '0;
    end
    for (int k = 0; k < N_PORTS; k++) begin
      idx_ext = start + (PORT_W+1)'(k);
      if (idx_ext >= NP) idx_ext = idx_ext - NP;
      if (!win_found && req[idx_ext[PORT_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_ext[PORT_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win_idx == PORT_W'(i)) begin
        sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = s_wstrb[i*NBYTES +: NBYTES];
      end
    end
  end

  assign capture = win_found && ((state == IDLE) || m_ready);
  assign s_ready = ((state == BUSY) && m_ready) ? grant_oh : '0;
  assign s_rdata = {N_PORTS{m_rdata}};
  assign busy    = m_valid;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      grant_id   <= '0;
      last_grant <= PORT_W'(N_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state   <= BUSY;
            m_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (m_ready && !capture) begin
            state   <= IDLE;
            m_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
      if (capture) begin
        m_addr     <= sel_addr;
        m_wdata    <= sel_wdata;
        m_wstrb    <= sel_wstrb;
        grant_id   <= win_idx;
        last_grant <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_iob_cache_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side and compares
// both against a transaction-level model of the arbitration rules.
module tb_iob_cache_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    s_valid [2];
  logic [N*AW-1:0] s_addr  [2];
  logic [N*DW-1:0] s_wdata [2];
  logic [N*NB-1:0] s_wstrb [2];
  logic [N*DW-1:0] s_rdata [2];
  logic [N-1:0]    s_ready [2];
  logic            m_valid [2];
  logic [AW-1:0]   m_addr  [2];
  logic [DW-1:0]   m_wdata [2];
  logic [NB-1:0]   m_wstrb [2];
  logic [DW-1:0]   m_rdata [2];
  logic            m_ready [2];
  logic [PW-1:0]   grant_id[2];
  logic            busy    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    iob_cache_port_arbiter #(
      .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .NBYTES(NB), .ARB_MODE(g)
    ) dut (
      .ap_clk(clk), .reset(reset),
      .s_valid(s_valid[g]), .s_addr(s_addr[g]), .s_wdata(s_wdata[g]),
      .s_wstrb(s_wstrb[g]), .s_rdata(s_rdata[g]), .s_ready(s_ready[g]),
      .m_valid(m_valid[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_wstrb(m_wstrb[g]), .m_rdata(m_rdata[g]), .m_ready(m_ready[g]),
      .grant_id(grant_id[g]), .busy(busy[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  string nm[2] = '{"rr", "fp"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: one outstanding request per instance.
  bit            md_busy [2];
  int            md_grant[2];
  int            md_last [2];
  logic [AW-1:0] md_addr [2];
  logic [DW-1:0] md_wdata[2];
  logic [NB-1:0] md_wstrb[2];
  logic [N-1:0]  md_done [2];

  function automatic int pick(input logic [N-1:0] r, input int last, input int mode);
    int first;
    first = (mode == 1) ? 0 : (last + 1) % N;
    for (int k = 0; k < N; k++) begin
      if (r[(first + k) % N]) return (first + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset(input int k);
    md_busy[k]  = 1'b0;
    md_grant[k] = 0;
    md_last[k]  = N - 1;
    md_addr[k]  = '0;
    md_wdata[k] = '0;
    md_wstrb[k] = '0;
  endtask

  task automatic take(input int k, input int w);
    md_busy[k]  = 1'b1;
    md_grant[k] = w;
    md_last[k]  = w;
    md_addr[k]  = s_addr[k][w*AW +: AW];
    md_wdata[k] = s_wdata[k][w*DW +: DW];
    md_wstrb[k] = s_wstrb[k][w*NB +: NB];
  endtask

  // Compare this cycle's outputs, then advance the model across the next edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] r;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = (md_busy[k] && m_ready[k]) ? (N'(1) << md_grant[k]) : '0;
      check($sformatf("%s m_valid", nm[k]), 64'(m_valid[k]), 64'(md_busy[k]));
      check($sformatf("%s busy", nm[k]), 64'(busy[k]), 64'(md_busy[k]));
      check($sformatf("%s grant_id", nm[k]), 64'(grant_id[k]), 64'(md_grant[k]));
      check($sformatf("%s m_addr", nm[k]), 64'(m_addr[k]), 64'(md_addr[k]));
      check($sformatf("%s m_wdata", nm[k]), 64'(m_wdata[k]), 64'(md_wdata[k]));
      check($sformatf("%s m_wstrb", nm[k]), 64'(m_wstrb[k]), 64'(md_wstrb[k]));
      check($sformatf("%s s_ready", nm[k]), 64'(s_ready[k]), 64'(exp_rdy));
      if (exp_rdy != '0)
        check($sformatf("%s s_rdata", nm[k]), 64'(s_rdata[k][md_grant[k]*DW +: DW]), 64'(m_rdata[k]));
      md_done[k] = exp_rdy;
      if (reset) model_reset(k);
      else if (!md_busy[k]) begin
        if (s_valid[k] != '0) take(k, pick(s_valid[k], md_last[k], k));
      end else if (m_ready[k]) begin
        r = s_valid[k] & ~(N'(1) << md_grant[k]);
        if (r != '0) take(k, pick(r, md_last[k], k));
        else md_busy[k] = 1'b0;
      end
    end
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic mr, input logic [DW-1:0] rd, input logic rst);
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = v;
      m_ready[k] = mr;
      m_rdata[k] = rd;
    end
    reset = rst;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] st);
    for (int k = 0; k < 2; k++) begin
      s_addr[k][p*AW +: AW]  = a;
      s_wdata[k][p*DW +: DW] = d;
      s_wstrb[k][p*NB +: NB] = st;
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic mr, input logic [DW-1:0] rd, input logic rst);
    @(negedge clk);
    set_in(v, mr, rd, rst);
    step();
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_addr[k] = '0; s_wdata[k] = '0; s_wstrb[k] = '0;
      md_done[k] = '0;
      model_reset(k);
    end
    set_in('0, 1'b0, '0, 1'b1);
    @(posedge clk);

    // Single read on port 2.
    cyc('0, 1'b0, '0, 1'b1);
    @(negedge clk);
    set_port(2, 16'h1000, '0, '0);
    set_in(4'b0100, 1'b0, '0, 1'b0);
    step();
    cyc(4'b0100, 1'b0, '0, 1'b0);
    check("read m_valid", 64'(m_valid[0]), 64'd1);
    check("read m_addr", 64'(m_addr[0]), 64'h1000);
    check("read grant", 64'(grant_id[0]), 64'd2);
    cyc(4'b0100, 1'b0, '0, 1'b0);
    cyc(4'b0100, 1'b1, 32'hA5, 1'b0);
    check("read s_ready", 64'(s_ready[0]), 64'b0100);
    check("read s_rdata", 64'(s_rdata[0][2*DW +: DW]), 64'hA5);
    cyc('0, 1'b0, '0, 1'b0);
    check("read done m_valid", 64'(m_valid[0]), 64'd0);

    // Round-robin fairness with all ports requesting.
    cyc('0, 1'b0, '0, 1'b1);
    cyc(4'hF, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, 1'b1, 32'(i), 1'b0);
      check($sformatf("rr order %0d", i), 64'(grant_id[0]), 64'(order[i]));
      check($sformatf("rr no bubble %0d", i), 64'(m_valid[0]), 64'd1);
    end

    // Fixed priority, ports 1 and 3.
    cyc('0, 1'b0, '0, 1'b1);
    cyc(4'b1010, 1'b0, '0, 1'b0);
    cyc(4'b1010, 1'b1, 32'h1, 1'b0);
    check("fp first", 64'(grant_id[1]), 64'd1);
    check("fp first ready", 64'(s_ready[1]), 64'b0010);
    cyc(4'b1000, 1'b0, '0, 1'b0);
    check("fp second", 64'(grant_id[1]), 64'd3);
    cyc(4'b1010, 1'b0, '0, 1'b0);
    cyc(4'b1010, 1'b1, 32'h3, 1'b0);
    check("fp second ready", 64'(s_ready[1]), 64'b1000);
    cyc(4'b0010, 1'b0, '0, 1'b0);
    check("fp reassert", 64'(grant_id[1]), 64'd1);

    // Fields frozen while in flight.
    cyc('0, 1'b0, '0, 1'b1);
    @(negedge clk);
    set_port(0, 16'h0040, 32'h11, 4'hF);
    set_in(4'b0001, 1'b0, '0, 1'b0);
    step();
    @(negedge clk);
    set_port(0, 16'h0040, 32'h22, 4'hF);
    set_in(4'b0001, 1'b0, '0, 1'b0);
    step();
    check("frozen wdata a", 64'(m_wdata[0]), 64'h11);
    cyc(4'b0001, 1'b1, '0, 1'b0);
    check("frozen wdata b", 64'(m_wdata[0]), 64'h11);
    check("frozen ready", 64'(s_ready[0]), 64'b0001);

    // Spurious m_ready while idle.
    cyc('0, 1'b0, '0, 1'b0);
    cyc('0, 1'b1, 32'h5, 1'b0);
    check("spurious s_ready", 64'(s_ready[0]), 64'd0);
    cyc('0, 1'b0, '0, 1'b0);
    check("spurious m_valid", 64'(m_valid[0]), 64'd0);

    // Reset in the middle of a port 1 access.
    cyc('0, 1'b0, '0, 1'b1);
    cyc(4'b0010, 1'b0, '0, 1'b0);
    cyc(4'b0010, 1'b0, '0, 1'b1);
    check("rst before grant", 64'(grant_id[0]), 64'd1);
    cyc(4'b0011, 1'b0, '0, 1'b0);
    check("rst m_valid", 64'(m_valid[0]), 64'd0);
    check("rst grant", 64'(grant_id[0]), 64'd0);
    check("rst s_ready", 64'(s_ready[0]), 64'd0);
    cyc(4'b0011, 1'b0, '0, 1'b0);
    check("rst then port0", 64'(grant_id[0]), 64'd0);

    // Randomized traffic, masters following the valid/ready protocol.
    for (int k = 0; k < 2; k++) s_valid[k] = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < N; p++) begin
          if (md_done[k][p]) s_valid[k][p] = 1'b0;
          if (!s_valid[k][p] && $urandom_range(0, 99) < 30) begin
            s_valid[k][p] = 1'b1;
            s_addr[k][p*AW +: AW]  = AW'($urandom);
            s_wdata[k][p*DW +: DW] = $urandom;
            s_wstrb[k][p*NB +: NB] = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
          end else if (s_valid[k][p] && $urandom_range(0, 99) < 10) begin
            s_wdata[k][p*DW +: DW] = $urandom;
          end
        end
        m_ready[k] = md_busy[k] ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 15);
        m_rdata[k] = $urandom;
      end
      reset = ($urandom_range(0, 99) < 2);
      if (reset) begin
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iob_cache_port_arbiter.md
# iob_cache_port_arbiter

Multi-port front end for the IOb/AXI cache: merges `N_PORTS` IOb-native master ports onto the single frontend port of `iob_cache_axi` (`valid`/`addr`/`wdata`/`wstrb`/`rdata`/`ready`). Arbitration is round-robin or fixed-priority. The granted request is registered, so masters cannot disturb an in-flight cache access. Responses return to the granted port only, and back-to-back grants sustain one request per cache access.

## Interface
- `N_PORTS`, 4: number of slave ports, 2..16.
- `ADDR_W`, 64: request address width; matches the cache `CACHE_FRONTEND_ADDR_W`.
- `DATA_W`, 512: data width; matches the cache `CACHE_FRONTEND_DATA_W`.
- `NBYTES`, `DATA_W/8`: strobe width.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `PORT_W`, `$clog2(N_PORTS)`: grant index width. Do not override.
- `ap_clk`, in, 1: the only clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `s_valid`, in, `N_PORTS`: per-port request; held high until the matching `s_ready` pulse.
- `s_addr`, in, `N_PORTS*ADDR_W`: flattened addresses; port i occupies `[i*ADDR_W +: ADDR_W]`.
- `s_wdata`, in, `N_PORTS*DATA_W`: flattened write data.
- `s_wstrb`, in, `N_PORTS*NBYTES`: flattened strobes; all-zero means read.
- `s_rdata`, out, `N_PORTS*DATA_W`: every slice equals `m_rdata`; qualified by `s_ready`.
- `s_ready`, out, `N_PORTS`: one-cycle completion pulse, at most one bit high.
- `m_valid`, out, 1: request to the cache, registered.
- `m_addr`, out, `ADDR_W`: registered copy of the granted request field.
- `m_wdata`, out, `DATA_W`: registered copy of the granted request field.
- `m_wstrb`, out, `NBYTES`: registered copy of the granted request field.
- `m_rdata`, in, `DATA_W`: cache read data.
- `m_ready`, in, 1: cache completion pulse.
- `grant_id`, out, `PORT_W`: index of the port currently or last granted.
- `busy`, out, 1: equals `m_valid`.

## Operation
- State machine with two states: IDLE and BUSY.
- **IDLE**
  - If any `s_valid` bit is high, select a winner and capture its `addr`/`wdata`/`wstrb` into the `m_*` registers.
  - Set `grant_id` to the winner, set `m_valid=1`, and go to BUSY at the next edge.
  - If no `s_valid` bit is high, stay in IDLE.
- **BUSY**
  - `m_*` fields are frozen until `m_ready`.
  - In the `m_ready` cycle, `s_ready[grant_id]=1` combinationally. The other `s_ready` bits are 0.
  - In the same `m_ready` cycle, arbitrate among `s_valid` with the bit for `grant_id` masked, because that master still shows valid this cycle.
    - If a winner exists: capture it and stay in BUSY, keeping `m_valid=1` (back-to-back).
    - Otherwise: clear `m_valid` and go to IDLE.
- **Round-robin:** search starts at `(last_grant+1) mod N_PORTS` and wraps past `N_PORTS-1` to 0. `last_grant` updates on every capture. After reset `last_grant=N_PORTS-1`, so port 0 has first priority.
- **Fixed priority:** the lowest set index wins; starvation is permitted.
- `m_ready` while `m_valid=0` is ignored: no `s_ready` pulse and no state change.
- `s_valid` dropping on the granted port mid-flight does not cancel the request; it completes normally.
- **Reset values:** state IDLE, `m_valid=0`, `m_addr=0`, `m_wdata=0`, `m_wstrb=0`, `grant_id=0`, `busy=0`, `s_ready=0`, `last_grant=N_PORTS-1`.
- **Reset asserted mid-transaction:** the in-flight request is discarded and no `s_ready` is issued for it. `m_valid=0` at the cycle after the reset edge.

## Timing
- Request latency: `s_valid` high in cycle t while IDLE gives `m_valid` high in cycle t+1.
- Completion: `s_ready` appears in the same cycle as `m_ready`, with zero added latency.
- Back-to-back: with a waiting port, `m_valid` stays high across the `m_ready` edge and new fields appear in cycle t+1. Sustained throughput is one request per cache access, with no idle bubble.
- Simultaneous new `s_valid` and `m_ready`: the new request is eligible in that same cycle.
- No combinational path from `s_*` to `m_*`. `s_ready` and `s_rdata` are combinational from `m_ready`/`m_rdata`.

## Test plan
- **Single read:** port 2 only, `s_addr=0x1000`, `wstrb=0`; cache answers `m_ready` 3 cycles later with `rdata=0xA5`.
  - Required: `m_valid` at t+1, `m_addr=0x1000`, `grant_id=2`.
  - Required: `s_ready=4'b0100` for one cycle with `s_rdata[2]=0xA5`, then `m_valid=0`.
- **Round-robin fairness:** all 4 ports hold valid continuously; `m_ready` 1 cycle after each `m_valid`.
  - Required: grant order 0,1,2,3,0, with `m_valid` never deasserting between grants.
- **Fixed priority:** `ARB_MODE=1`, ports 1 and 3 valid.
  - Required: port 1 is served first, then port 3.
  - Required: if port 1 re-asserts during port 3's access, port 1 is served next.
- **Frozen fields:** port 0 write `wdata=0x11` is granted, then `s_wdata[0]` changes to `0x22` before `m_ready`.
  - Required: `m_wdata` stays `0x11` until completion.
- **Spurious ready:** `m_ready=1` while IDLE.
  - Required: no `s_ready` and state unchanged.
- **Reset mid-flight:** `reset` is asserted one cycle into BUSY with port 1 granted.
  - Required: `m_valid=0`, `grant_id=0`, and no `s_ready` pulse.
  - Required: afterwards, with ports 0 and 1 valid, port 0 is served first.
